// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: register map,
// STATUS bit layout, FSM state encodings and the bus request record.
package uart_tx_sched_pkg;

  localparam logic [31:0] REG_CTRL   = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS = 32'h0000_0004;
  localparam logic [31:0] REG_BAUD   = 32'h0000_0008;
  localparam logic [31:0] REG_TXDATA = 32'h0000_000C;
  localparam logic [31:0] REG_RXDATA = 32'h0000_0010;

  // STATUS bit that reads 1 while the transmitter is still shifting
  localparam int STATUS_TX_BUSY = 0;

  typedef enum logic [7:0] {
    S_INIT      = 8'b0000_0001,
    S_INIT_RSP  = 8'b0000_0010,
    S_IDLE      = 8'b0000_0100,
    S_POLL      = 8'b0000_1000,
    S_POLL_RSP  = 8'b0001_0000,
    S_WAIT      = 8'b0010_0000,
    S_WRITE     = 8'b0100_0000,
    S_WRITE_RSP = 8'b1000_0000
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } bus_req_t;

  localparam bus_req_t REQ_NONE = '0;

  // Build a valid request; the UART only ever takes byte lane 0
  function automatic bus_req_t mk_req(input logic        we,
                                      input logic [31:0] addr,
                                      input logic [31:0] data);
    bus_req_t r;
    r.valid = 1'b1;
    r.we    = we;
    r.addr  = addr;
    r.data  = data;
    r.sel   = 4'b0001;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_sched_fifo.sv
// Generic synchronous FIFO with registered occupancy and a
// combinational head output (first-word fall-through read).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Storage needs no reset: nothing is read until the count says so
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between two byte producers: round-robin
// arbitration into a byte FIFO, then a bus-master FSM that polls STATUS
// and writes TXDATA so software never spins on the UART.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          FIFO_DEPTH = 8,
  parameter int          POLL_GAP   = 16,
  parameter logic        RX_EN      = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        src0_valid_i,
  input  logic [7:0]                  src0_data_i,
  output logic                        src0_ready_o,
  input  logic                        src1_valid_i,
  input  logic [7:0]                  src1_data_i,
  output logic                        src1_ready_o,
  output logic [31:0]                 addr_o,
  output logic [31:0]                 data_o,
  output logic [3:0]                  sel_o,
  output logic                        we_o,
  output logic                        req_valid_o,
  input  logic                        req_ready_i,
  input  logic [31:0]                 data_i,
  input  logic                        rsp_valid_i,
  output logic                        rsp_ready_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o
);

  localparam int GAP_W = $clog2(POLL_GAP + 2);

  state_e                      state;
  bus_req_t                    req_q;
  bus_req_t                    poll_req;
  logic [GAP_W-1:0]            gap_cnt;
  logic                        rr;        // 0: src0 wins a tie, 1: src1 wins
  logic                        grant0;
  logic                        grant1;
  logic                        push;
  logic                        pop;
  logic [7:0]                  push_data;
  logic [7:0]                  fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        unused_rdata;

  // Only the TX busy bit of the read data matters here
  assign unused_rdata = ^data_i;

  // Grant at most one source per cycle; full blocks both, even on a pop
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && !fifo_full) begin
      if (src0_valid_i && (!src1_valid_i || !rr)) grant0 = 1'b1;
      else if (src1_valid_i)                      grant1 = 1'b1;
    end
  end

  assign src0_ready_o = grant0;
  assign src1_ready_o = grant1;
  assign push         = grant0 | grant1;
  assign push_data    = grant1 ? src1_data_i : src0_data_i;

  // After each accepted push, favour the source that was not just served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr <= 1'b0;
    else if (grant0) rr <= 1'b1;
    else if (grant1) rr <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The head byte leaves the FIFO the moment the UART takes the write
  assign pop      = (state == S_WRITE) && req_ready_i;
  assign poll_req = mk_req(1'b0, BASE_ADDR + REG_STATUS, 32'h0);

  // Bus master: one transaction in flight, request/response outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      req_q       <= REQ_NONE;
      rsp_ready_o <= 1'b0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        S_INIT: begin
          if (req_q.valid && req_ready_i) begin
            req_q       <= REQ_NONE;
            rsp_ready_o <= 1'b1;
            state       <= S_INIT_RSP;
          end else begin
            req_q <= mk_req(1'b1, BASE_ADDR + REG_CTRL, {30'b0, RX_EN, 1'b1});
          end
        end
        S_INIT_RSP: begin
          if (rsp_valid_i) begin
            rsp_ready_o <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (!fifo_empty) begin
            req_q <= poll_req;
            state <= S_POLL;
          end
        end
        S_POLL: begin
          if (req_ready_i) begin
            req_q       <= REQ_NONE;
            rsp_ready_o <= 1'b1;
            state       <= S_POLL_RSP;
          end
        end
        S_POLL_RSP: begin
          if (rsp_valid_i) begin
            rsp_ready_o <= 1'b0;
            if (!data_i[STATUS_TX_BUSY]) begin
              req_q <= mk_req(1'b1, BASE_ADDR + REG_TXDATA, {24'b0, fifo_head});
              state <= S_WRITE;
            end else if (POLL_GAP == 0) begin
              req_q <= poll_req;
              state <= S_POLL;
            end else begin
              gap_cnt <= GAP_W'(POLL_GAP);
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Leaving on the count of 1 puts the next STATUS read POLL_GAP+1
          // cycles after the busy response
          if (gap_cnt <= GAP_W'(1)) begin
            gap_cnt <= '0;
            req_q   <= poll_req;
            state   <= S_POLL;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        S_WRITE: begin
          if (req_ready_i) begin
            req_q       <= REQ_NONE;
            rsp_ready_o <= 1'b1;
            state       <= S_WRITE_RSP;
          end
        end
        S_WRITE_RSP: begin
          if (rsp_valid_i) begin
            rsp_ready_o <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_INIT;
          req_q       <= REQ_NONE;
          rsp_ready_o <= 1'b0;
          gap_cnt     <= '0;
        end
      endcase
    end
  end

  assign req_valid_o = req_q.valid;
  assign we_o        = req_q.we;
  assign addr_o      = req_q.addr;
  assign data_o      = req_q.data;
  assign sel_o       = req_q.sel;
  assign fifo_cnt_o  = fifo_cnt;
  // Gated so every output reads 0 while reset is held
  assign busy_o      = rst_n && (!fifo_empty || (state != S_IDLE));

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: a UART slave model, a byte-queue reference model
// checked every cycle, a table of arbitration vectors and directed sequences.
module tb_uart_tx_sched;

  localparam logic [31:0] BASE  = 32'h4000_1000;
  localparam int          DEPTH = 8;
  localparam int          GAP   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        src0_valid_i = 1'b0, src1_valid_i = 1'b0;
  logic [7:0]  src0_data_i = 8'h0, src1_data_i = 8'h0;
  logic        src0_ready_o, src1_ready_o;
  logic [31:0] addr_o, data_o;
  logic [3:0]  sel_o;
  logic        we_o, req_valid_o, rsp_ready_o, busy_o;
  logic        req_ready_i = 1'b1;
  logic [31:0] data_i = 32'h0;
  logic        rsp_valid_i = 1'b0;
  logic [3:0]  fifo_cnt_o;

  always #5 clk = ~clk;

  uart_tx_sched #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .POLL_GAP(GAP), .RX_EN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .src0_valid_i(src0_valid_i), .src0_data_i(src0_data_i), .src0_ready_o(src0_ready_o),
    .src1_valid_i(src1_valid_i), .src1_data_i(src1_data_i), .src1_ready_o(src1_ready_o),
    .addr_o(addr_o), .data_o(data_o), .sel_o(sel_o), .we_o(we_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .data_i(data_i), .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .busy_o(busy_o), .fifo_cnt_o(fifo_cnt_o));

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic we; logic [31:0] addr; logic [31:0] data; } txn_t;
  typedef struct { int c; logic [31:0] data; } rsp_t;
  typedef struct { logic v0, v1; logic [7:0] d0, d1; logic r0, r1; int cnt; } vec_t;

  txn_t        tlog[$];
  rsp_t        rlog[$];
  logic [7:0]  model_q[$];     // bytes accepted but not yet written to TXDATA
  logic [7:0]  acc_log[$];
  int          push_cyc[$], pop_cyc[$];
  logic [31:0] pend_q[$];      // responses owed by the UART model
  int          busy_q[$];      // scripted STATUS answers
  bit          rand_status = 0, rsp_hold = 0;
  bit          mptr = 0;       // which source wins the next tie

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // UART slave plus reference model, observed mid-cycle
  initial begin : monitor
    bit   prev_pend, drop, e0, e1, full;
    txn_t prev, t;
    rsp_t r;
    prev_pend = 0;
    forever begin
      @(negedge clk);
      drop = 0;
      if (!rst_n) begin
        model_q.delete(); pend_q.delete(); rsp_valid_i = 1'b0;
        mptr = 0; prev_pend = 0;
      end else begin
        chk("fifo_cnt", fifo_cnt_o, model_q.size());
        full = model_q.size() >= DEPTH;
        e0 = !full && src0_valid_i && (!src1_valid_i || !mptr);
        e1 = !full && src1_valid_i && !e0;
        chk("src0_ready", src0_ready_o, e0);
        chk("src1_ready", src1_ready_o, e1);
        if (prev_pend)
          chk("req_hold", req_valid_o && we_o == prev.we && addr_o == prev.addr && data_o == prev.data, 1);
        if (req_valid_o) chk("one_outstanding", pend_q.size(), 0);
        if (rsp_valid_i && rsp_ready_o) begin
          r.c = cyc; r.data = data_i; rlog.push_back(r);
          void'(pend_q.pop_front()); drop = 1;
        end
        if (req_valid_o && req_ready_i) begin
          t.c = cyc; t.we = we_o; t.addr = addr_o; t.data = data_o;
          tlog.push_back(t);
          chk("sel", sel_o, 4'b0001);
          if (we_o && addr_o == BASE + 32'hC) begin
            if (model_q.size() == 0) chk("txdata_unexpected", 1, 0);
            else begin
              chk("txdata_order", data_o, {24'h0, model_q[0]});
              void'(model_q.pop_front());
              pop_cyc.push_back(cyc);
            end
          end
          if (!we_o && addr_o == BASE + 32'h4) begin
            if (busy_q.size() != 0)  pend_q.push_back(busy_q.pop_front());
            else if (rand_status)    pend_q.push_back(($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0);
            else                     pend_q.push_back(32'h0);
          end else pend_q.push_back(32'h0);
        end
        prev_pend = req_valid_o && !req_ready_i;
        prev.we = we_o; prev.addr = addr_o; prev.data = data_o;
        if (src0_valid_i && src0_ready_o) begin
          model_q.push_back(src0_data_i); acc_log.push_back(src0_data_i); push_cyc.push_back(cyc); mptr = 1;
        end else if (src1_valid_i && src1_ready_o) begin
          model_q.push_back(src1_data_i); acc_log.push_back(src1_data_i); push_cyc.push_back(cyc); mptr = 0;
        end
      end
      @(posedge clk); #1;
      if (rst_n) begin
        if (drop) rsp_valid_i = 1'b0;
        if (!rsp_valid_i && pend_q.size() != 0 && !rsp_hold) begin
          rsp_valid_i = 1'b1; data_i = pend_q[0];
        end else if (!rsp_valid_i) data_i = $urandom;
      end
    end
  end

  task automatic wait_idle(input string name, input int budget);
    bit ok = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick();
      if (!busy_o && !req_valid_o && pend_q.size() == 0) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget); end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_valid"}, req_valid_o, 0); chk({tag, "_addr"}, addr_o, 0);
    chk({tag, "_data"}, data_o, 0);           chk({tag, "_sel"}, sel_o, 0);
    chk({tag, "_we"}, we_o, 0);               chk({tag, "_rsp_ready"}, rsp_ready_o, 0);
    chk({tag, "_src0_ready"}, src0_ready_o, 0); chk({tag, "_src1_ready"}, src1_ready_o, 0);
    chk({tag, "_busy"}, busy_o, 0);           chk({tag, "_fifo_cnt"}, fifo_cnt_o, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3; rst_n = 1'b0;
    repeat (2) @(posedge clk); #1; rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t tbl[11];
    int n0, r0, p0, a0, ia, ib;
    bit got;
    tbl[0]  = '{1'b1, 1'b1, 8'h10, 8'h20, 1'b1, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b1, 8'h11, 8'h21, 1'b0, 1'b1, 1};
    tbl[2]  = '{1'b0, 1'b1, 8'h12, 8'h22, 1'b0, 1'b1, 2};
    tbl[3]  = '{1'b1, 1'b1, 8'h13, 8'h23, 1'b1, 1'b0, 3};
    tbl[4]  = '{1'b1, 1'b0, 8'h14, 8'h24, 1'b1, 1'b0, 4};
    tbl[5]  = '{1'b1, 1'b1, 8'h15, 8'h25, 1'b0, 1'b1, 5};
    tbl[6]  = '{1'b0, 1'b0, 8'h16, 8'h26, 1'b0, 1'b0, 6};
    tbl[7]  = '{1'b1, 1'b1, 8'h17, 8'h27, 1'b1, 1'b0, 6};
    tbl[8]  = '{1'b0, 1'b1, 8'h18, 8'h28, 1'b0, 1'b1, 7};
    tbl[9]  = '{1'b1, 1'b1, 8'h19, 8'h29, 1'b0, 1'b0, 8};
    tbl[10] = '{1'b1, 1'b0, 8'h1A, 8'h2A, 1'b0, 1'b0, 8};

    // Reset state, with a source already offering a byte
    src0_valid_i = 1'b1; #12;
    chk_all_zero("reset");
    src0_valid_i = 1'b0;
    tick(); rst_n = 1'b1;
    wait_idle("init_idle", 50);
    if (tlog.size() > 0) begin
      chk("init_we", tlog[0].we, 1); chk("init_addr", tlog[0].addr, BASE);
      chk("init_data", tlog[0].data, 32'h1);
    end else chk("init_seen", 0, 1);
    repeat (3) tick();
    chk("idle_req_valid", req_valid_o, 0);

    // Single byte, UART ready: push at N, poll request at N+2
    n0 = tlog.size();
    tick(); src0_valid_i = 1'b1; src0_data_i = 8'h55;
    @(negedge clk); chk("push55_ready", src0_ready_o, 1);
    tick(); src0_valid_i = 1'b0;
    chk("n1_req_valid", req_valid_o, 0);
    tick();
    chk("n2_req_valid", req_valid_o, 1); chk("n2_addr", addr_o, BASE + 32'h4); chk("n2_we", we_o, 0);
    wait_idle("single_drain", 100);
    chk("single_ntxn", tlog.size() - n0, 2);
    if (tlog.size() >= n0 + 2) begin
      chk("single_rd_addr", tlog[n0].addr, BASE + 32'h4);
      chk("single_wr_addr", tlog[n0+1].addr, BASE + 32'hC);
      chk("single_wr_data", tlog[n0+1].data, 32'h55);
    end
    chk("single_cnt", fifo_cnt_o, 0); chk("single_busy", busy_o, 0);

    // Three busy STATUS answers, then ready
    busy_q = '{1, 1, 1};
    n0 = tlog.size(); r0 = rlog.size();
    tick(); src1_valid_i = 1'b1; src1_data_i = 8'h66;
    tick(); src1_valid_i = 1'b0;
    wait_idle("busy_drain", 300);
    chk("busy_ntxn", tlog.size() - n0, 5);
    if (tlog.size() >= n0 + 5 && rlog.size() >= r0 + 3) begin
      for (int k = 0; k < 4; k++) chk("busy_rd_addr", tlog[n0+k].addr, BASE + 32'h4);
      for (int k = 0; k < 3; k++) chk("busy_gap", tlog[n0+k+1].c - rlog[r0+k].c, GAP + 1);
      chk("busy_wr_data", tlog[n0+4].data, 32'h66);
    end

    // Both sources streaming: strict alternation starting with src0
    a0 = acc_log.size(); ia = 0; ib = 0;
    for (int k = 0; k < 600 && (ia < 8 || ib < 8); k++) begin
      tick();
      src0_valid_i = (ia < 8); src0_data_i = 8'hA0 + 8'(ia);
      src1_valid_i = (ib < 8); src1_data_i = 8'hB0 + 8'(ib);
      @(negedge clk);
      if (src0_valid_i && src0_ready_o) ia++;
      if (src1_valid_i && src1_ready_o) ib++;
    end
    tick(); src0_valid_i = 1'b0; src1_valid_i = 1'b0;
    wait_idle("rr_drain", 1000);
    chk("rr_count", acc_log.size() - a0, 16);
    if (acc_log.size() >= a0 + 16)
      for (int k = 0; k < 16; k++)
        chk("rr_order", acc_log[a0+k], ((k % 2) ? 8'hB0 : 8'hA0) + 8'(k / 2));

    // Random traffic against the model
    rand_status = 1; p0 = pop_cyc.size(); a0 = acc_log.size();
    for (int k = 0; k < 400; k++) begin
      tick();
      src0_valid_i = $urandom_range(0, 1); src0_data_i = 8'($urandom);
      src1_valid_i = $urandom_range(0, 1); src1_data_i = 8'($urandom);
      req_ready_i  = ($urandom_range(0, 3) != 0);
    end
    tick(); src0_valid_i = 1'b0; src1_valid_i = 1'b0; req_ready_i = 1'b1;
    wait_idle("rand_drain", 3000);
    rand_status = 0;
    chk("rand_all_written", pop_cyc.size() - p0, acc_log.size() - a0);

    // Fill to full with the UART stalled, table-driven
    do_reset(); wait_idle("reset2_idle", 50);
    req_ready_i = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      src0_valid_i = tbl[i].v0; src0_data_i = tbl[i].d0;
      src1_valid_i = tbl[i].v1; src1_data_i = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("tbl%0d_cnt", i), fifo_cnt_o, tbl[i].cnt);
      chk($sformatf("tbl%0d_r0", i), src0_ready_o, tbl[i].r0);
      chk($sformatf("tbl%0d_r1", i), src1_ready_o, tbl[i].r1);
    end
    tick(); src1_valid_i = 1'b0; src0_valid_i = 1'b1; src0_data_i = 8'h99;
    p0 = pop_cyc.size(); req_ready_i = 1'b1; got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (src0_ready_o) got = 1;
      else begin @(posedge clk); #1; end
    end
    tick(); src0_valid_i = 1'b0;
    chk("ninth_accepted", got, 1);
    if (got && pop_cyc.size() > p0) chk("ninth_after_pop", push_cyc[$] - pop_cyc[p0], 1);
    wait_idle("full_drain", 1000);
    chk("full_writes", pop_cyc.size() - p0, 9);

    // Reset while waiting on a STATUS response with 3 bytes queued
    rsp_hold = 1;
    for (int k = 0; k < 3; k++) begin
      tick(); src0_valid_i = 1'b1; src0_data_i = 8'hC0 + 8'(k);
    end
    tick(); src0_valid_i = 1'b0;
    repeat (3) tick();
    chk("pre_rst_rsp_ready", rsp_ready_o, 1); chk("pre_rst_cnt", fifo_cnt_o, 3);
    #2; rst_n = 1'b0; #1;
    chk_all_zero("midrst");
    rsp_hold = 0;
    tick(); tick(); rst_n = 1'b1;
    n0 = tlog.size(); p0 = pop_cyc.size();
    repeat (60) tick();
    chk("rst_init_seen", tlog.size() - n0, 1);
    if (tlog.size() > n0) begin
      chk("rst_init_addr", tlog[n0].addr, BASE); chk("rst_init_data", tlog[n0].data, 32'h1);
      chk("rst_init_we", tlog[n0].we, 1);
    end
    chk("rst_cnt", fifo_cnt_o, 0); chk("rst_no_txdata", pop_cyc.size() - p0, 0);
    chk("rst_busy", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Bus-master scheduler that shares the UART transmitter between two byte producers. It sits between two byte sources (e.g. CPU log path and debug path) and the UART peripheral's valid/ready register port. Accepted bytes go into an internal FIFO. The block drains the FIFO by polling UART_STATUS and writing UART_TXDATA, so the CPU never busy-waits on the UART.

## Interface
- BASE_ADDR, 32'h0, UART base address; register offsets are added to it
- FIFO_DEPTH, 8, byte FIFO depth (power of two, ≥2)
- POLL_GAP, 16, idle cycles between consecutive STATUS reads that return busy; 0 = back-to-back
- RX_EN, 1'b0, value written to UART_CTRL bit[1] during init
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- src0_valid_i / src1_valid_i  in  1  byte offered
- src0_data_i / src1_data_i  in  8  byte
- src0_ready_o / src1_ready_o  out  1  byte accepted this cycle when valid&ready
- addr_o  out  32  bus address
- data_o  out  32  bus write data
- sel_o  out  4  byte select; always 4'b0001
- we_o  out  1  1 = write, 0 = read
- req_valid_o  out  1  request valid
- req_ready_i  in  1  request accepted
- data_i  in  32  read data; valid when rsp_valid_i
- rsp_valid_i  in  1  response valid
- rsp_ready_o  out  1  response accepted
- busy_o  out  1  FIFO non-empty or FSM not in S_IDLE
- fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Reset values: all outputs 0, FSM in S_INIT, FIFO empty, round-robin pointer favours src0, gap counter 0.
- Arbitration:
  - When FIFO count < FIFO_DEPTH, one source is granted per cycle.
  - If only one source is valid, it is granted. If both are valid, the pointer chooses.
  - The pointer flips to the other source after each accepted push.
  - src*_ready_o is high only for the granted source. It is combinational from the valid inputs, the pointer and the registered count.
  - When full, both readies are low, even if a pop happens in the same cycle.
- FSM. Exactly one bus transaction is outstanding at a time.
  - S_INIT: write BASE+0x0, data {30'b0, RX_EN, 1'b1}. On accept, go to S_INIT_RSP.
  - S_INIT_RSP: on response, go to S_IDLE.
  - S_IDLE: if FIFO is non-empty, go to S_POLL.
  - S_POLL: read BASE+0x4. On accept, go to S_POLL_RSP.
  - S_POLL_RSP: on response, if data_i[0]=0 go to S_WRITE. If data_i[0]=1, load the gap counter with POLL_GAP and go to S_WAIT (go straight to S_POLL if POLL_GAP=0).
  - S_WAIT: decrement the counter; at 0, go to S_POLL.
  - S_WRITE: write BASE+0xC, data {24'b0, FIFO head}. On accept, pop the FIFO and go to S_WRITE_RSP.
  - S_WRITE_RSP: on response, go to S_IDLE.
- req_valid_o=1 in S_INIT, S_POLL and S_WRITE. Address, data and we_o stay stable until req_ready_i. Request outputs are 0 in other states.
- rsp_ready_o=1 only in the *_RSP states. Read data is sampled only on rsp_valid_i & rsp_ready_o.
- A push and a pop in the same cycle leave the count unchanged. Pointer wrap is modulo FIFO_DEPTH.
- Bytes leave the block in acceptance order.

## Timing
- Push at cycle N → count visible at N+1 → S_POLL at N+2 with req_valid_o high (empty FIFO, S_IDLE).
- Gap between a busy response and the next STATUS request is POLL_GAP+1 cycles.
- A response arriving in the same cycle as request acceptance is not possible. The UART response comes at the earliest one cycle after accept.
- Reset asserted mid-transaction: outputs drop asynchronously, FIFO contents are discarded, and the FSM restarts at S_INIT. Any in-flight UART response is ignored because rsp_ready_o=0 until S_INIT_RSP.

## Structure
- The shared include/package holds:
  - UART register offsets (CTRL 0x0, STATUS 0x4, BAUD 0x8, TXDATA 0xC, RXDATA 0x10)
  - the STATUS bit index for TX busy (0)
  - the FSM state encodings (one-hot, 8 states)
- Sub-module: sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH), holding the registered count and read/write pointers, with a combinational head output. It is reusable elsewhere.
- Arbiter, FSM and gap counter live in uart_tx_sched itself.

## Test plan
- Reset release with req_ready_i=1 → first request is write, addr=BASE+0x0, data=0x1, sel=4'b0001; then FSM idles with req_valid_o=0.
- src0 pushes 0x55; STATUS returns 0 → read at BASE+0x4, then write BASE+0xC data 0x55; fifo_cnt_o returns to 0 and busy_o drops.
- STATUS returns 1 three times then 0, with POLL_GAP=16 → four reads spaced 17 cycles from response to next request, then one TXDATA write.
- Both sources continuously valid with data src0=0xA0+i and src1=0xB0+i → accepted order A0,B0,A1,B1…; UART writes occur in the same order.
- req_ready_i held 0, push 9 bytes → readies low at count 8. After release, the 9th byte is accepted only in the cycle after the first pop; all 9 bytes are written in order.
- Reset asserted while in S_POLL_RSP with 3 bytes queued → all outputs 0. After release, the INIT write is repeated, fifo_cnt_o=0, and no TXDATA write occurs.
